// File: rtl/fft_stage_ctrl_pkg.sv
// Shared types and defaults for the in-place radix-2 FFT stage sequencer.
// Holds the FSM state encoding, default latencies and a width helper.
package fft_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam int DEF_MEM_RD_LAT = 1;
  localparam int DEF_BFLY_LAT   = 5;

  // Counter width that stays at least 1 bit for degenerate sizes.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fft_stage_ctrl_wr_delay.sv
// Parameterised shift register that replays read-side butterfly context
// {valid, addra, addrb, scale} DEPTH cycles later as write-side strobes.
module fft_stage_ctrl_wr_delay #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_reg [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) pipe_reg[gi] <= '0;
          else     pipe_reg[gi] <= din;
        end
      end else begin : g_body
        always_ff @(posedge clk or posedge rst) begin
          if (rst) pipe_reg[gi] <= '0;
          else     pipe_reg[gi] <= pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  assign dout = pipe_reg[DEPTH-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// Radix-2 in-place FFT stage sequencer: issues butterfly read pairs, twiddle
// indices and scale bits per stage, then delayed write-back on the same addresses.
module fft_stage_ctrl
  import fft_stage_ctrl_pkg::*;
#(
  parameter int LOG2N      = 10,
  parameter int MEM_RD_LAT = DEF_MEM_RD_LAT,
  parameter int BFLY_LAT   = DEF_BFLY_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LOG2N-1:0] scale_mask,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addra,
  output logic [LOG2N-1:0] rd_addrb,
  output logic [LOG2N-2:0] twiddle_addr,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addra,
  output logic [LOG2N-1:0] wr_addrb,
  output logic             scale
);

  localparam int WR_DELAY = MEM_RD_LAT + BFLY_LAT;
  localparam int HALF_N   = 2 ** (LOG2N - 1);
  localparam int KW       = LOG2N - 1;
  localparam int SW       = cnt_width(LOG2N);
  localparam int DW       = cnt_width(WR_DELAY);
  localparam int PW       = 2 + 2 * LOG2N;

  localparam logic [KW-1:0] K_LAST = KW'(HALF_N - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(WR_DELAY - 1);

  state_t           state_reg, state_next;
  logic [KW-1:0]    k_reg, k_next;
  logic [SW-1:0]    stage_reg, stage_next;
  logic [DW-1:0]    drain_reg, drain_next;
  logic [LOG2N-1:0] mask_reg, mask_next;
  logic             rd_scale_reg;

  logic [LOG2N-1:0] k_ext;
  logic [LOG2N-1:0] lo_mask;
  logic [LOG2N-1:0] addra_next, addrb_next;
  logic [KW-1:0]    tw_next;
  logic             run_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      k_reg     <= '0;
      stage_reg <= '0;
      drain_reg <= '0;
      mask_reg  <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      stage_reg <= stage_next;
      drain_reg <= drain_next;
      mask_reg  <= mask_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    stage_next = stage_reg;
    drain_next = drain_reg;
    mask_next  = mask_reg;
    case (state_reg)
      ST_IDLE: begin
        k_next     = '0;
        stage_next = '0;
        drain_next = '0;
        if (start) begin
          state_next = ST_RUN;
          mask_next  = scale_mask;
        end
      end
      ST_RUN: begin
        if (k_reg == K_LAST) begin
          state_next = ST_DRAIN;
          k_next     = '0;
          drain_next = '0;
        end else begin
          k_next = k_reg + KW'(1);
        end
      end
      ST_DRAIN: begin
        // Hold reads off until this stage's last write has landed in RAM.
        if (drain_reg == D_LAST) begin
          drain_next = '0;
          if (stage_reg == S_LAST) begin
            state_next = ST_FIN;
          end else begin
            state_next = ST_RUN;
            stage_next = stage_reg + SW'(1);
          end
        end else begin
          drain_next = drain_reg + DW'(1);
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
        k_next     = '0;
        stage_next = '0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Address generation from the next-state counters so the read outputs can be registered.
  always_comb begin
    run_next   = (state_next == ST_RUN);
    k_ext      = {1'b0, k_next};
    lo_mask    = ~({LOG2N{1'b1}} << stage_next);
    addra_next = (((k_ext >> stage_next) << 1) << stage_next) | (k_ext & lo_mask);
    addrb_next = addra_next | (LOG2N'(1) << stage_next);
    tw_next    = (k_next & lo_mask[KW-1:0]) << (S_LAST - stage_next);
    if (!run_next) begin
      addra_next = '0;
      addrb_next = '0;
      tw_next    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en        <= 1'b0;
      rd_addra     <= '0;
      rd_addrb     <= '0;
      twiddle_addr <= '0;
      rd_scale_reg <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      rd_en        <= run_next;
      rd_addra     <= addra_next;
      rd_addrb     <= addrb_next;
      twiddle_addr <= tw_next;
      rd_scale_reg <= run_next & mask_next[stage_next];
      busy         <= (state_next != ST_IDLE);
      done         <= (state_next == ST_FIN);
    end
  end

  logic [PW-1:0] wr_pipe_in, wr_pipe_out;

  assign wr_pipe_in = {rd_en, rd_addra, rd_addrb, rd_scale_reg};

  fft_stage_ctrl_wr_delay #(
    .WIDTH (PW),
    .DEPTH (WR_DELAY)
  ) u_wr_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (wr_pipe_in),
    .dout (wr_pipe_out)
  );

  assign {wr_en, wr_addra, wr_addrb, scale} = wr_pipe_out;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Randomised bench for fft_stage_ctrl at N=8: expected read/write schedules are
// derived from butterfly pair enumeration per stage, then compared cycle by cycle.
module tb_fft_stage_ctrl;

  localparam int LOG2N = 3;
  localparam int N     = 8;
  localparam int HALF  = 4;
  localparam int D     = 6;
  localparam int P     = HALF + D;
  localparam int L     = LOG2N;
  localparam int TOT   = L * P;
  localparam int MAXC  = TOT + 3;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] scale_mask;
  logic       busy, done, rd_en, wr_en, scale;
  logic [2:0] rd_addra, rd_addrb, wr_addra, wr_addrb;
  logic [1:0] twiddle_addr;

  fft_stage_ctrl #(
    .LOG2N      (LOG2N),
    .MEM_RD_LAT (1),
    .BFLY_LAT   (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .scale_mask   (scale_mask),
    .busy         (busy),
    .done         (done),
    .rd_en        (rd_en),
    .rd_addra     (rd_addra),
    .rd_addrb     (rd_addrb),
    .twiddle_addr (twiddle_addr),
    .wr_en        (wr_en),
    .wr_addra     (wr_addra),
    .wr_addrb     (wr_addrb),
    .scale        (scale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected per-cycle schedule, cycle 1 = first cycle after the accepting edge.
  logic       e_rd [1:MAXC];
  logic [2:0] e_a  [1:MAXC];
  logic [2:0] e_b  [1:MAXC];
  logic [1:0] e_tw [1:MAXC];
  logic       e_wr [1:MAXC];
  logic [2:0] e_wa [1:MAXC];
  logic [2:0] e_wb [1:MAXC];
  logic       e_sc [1:MAXC];
  logic       e_busy [1:MAXC];
  logic       e_done [1:MAXC];

  task automatic build_exp(input logic [2:0] mask);
    for (int c = 1; c <= MAXC; c++) begin
      e_rd[c] = 0; e_a[c] = 0; e_b[c] = 0; e_tw[c] = 0;
      e_wr[c] = 0; e_wa[c] = 0; e_wb[c] = 0; e_sc[c] = 0;
      e_busy[c] = (c <= TOT + 1);
      e_done[c] = (c == TOT + 1);
    end
    for (int s = 0; s < L; s++) begin
      int h;
      int j;
      h = 1 << s;
      j = 0;
      // Butterfly tops are the indices whose span-h block is even, in ascending order.
      for (int i = 0; i < N; i++) begin
        if (((i / h) % 2) == 0) begin
          int c;
          c = s * P + 1 + j;
          e_rd[c] = 1;
          e_a[c]  = 3'(i);
          e_b[c]  = 3'(i + h);
          e_tw[c] = 2'((i % h) * (N / (2 * h)));
          e_wr[c + D] = 1;
          e_wa[c + D] = 3'(i);
          e_wb[c + D] = 3'(i + h);
          e_sc[c + D] = mask[s];
          j++;
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 32'({busy, done, rd_en, rd_addra, rd_addrb, twiddle_addr,
                    wr_en, wr_addra, wr_addrb, scale}), 32'd0);
  endtask

  // Runs one transform; abort_at > 0 asserts rst in that cycle and stops checking.
  task automatic run_xfer(input logic [2:0] mask, input bit inject, input int abort_at);
    int n_inj;
    n_inj = 0;
    build_exp(mask);
    @(negedge clk);
    start      = 1'b1;
    scale_mask = mask;
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      check("rd_en", 32'(rd_en), 32'(e_rd[c]));
      if (e_rd[c])
        check("rd_pair", 32'({rd_addra, rd_addrb, twiddle_addr}),
              32'({e_a[c], e_b[c], e_tw[c]}));
      check("wr_en", 32'(wr_en), 32'(e_wr[c]));
      if (e_wr[c])
        check("wr_pair", 32'({wr_addra, wr_addrb, scale}),
              32'({e_wa[c], e_wb[c], e_sc[c]}));
      check("busy", 32'(busy), 32'(e_busy[c]));
      check("done", 32'(done), 32'(e_done[c]));
      if (c == abort_at) begin
        start = 1'b0;
        rst   = 1'b1;
        #1;
        check_all_zero("rst_now");
        $display("xfer mask=%b aborted by reset at cycle %0d", mask, c);
        break;
      end
      if (inject && c < TOT - 1 && $urandom_range(0, 3) == 0) begin
        start      = 1'b1;
        scale_mask = 3'($urandom);
        n_inj++;
      end else begin
        start = 1'b0;
      end
    end
    if (abort_at == 0)
      $display("xfer mask=%b inject=%0d stray_starts=%0d compared=%0d mismatched=%0d",
               mask, inject, n_inj, n_cmp, n_bad);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    scale_mask = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("idle_after_reset");

    run_xfer(3'b000, 1'b0, 0);
    run_xfer(3'b101, 1'b0, 0);
    run_xfer(3'b101, 1'b1, 0);

    // Reset during stage 1 drain, with stage 1 writes still in flight.
    run_xfer(3'b011, 1'b0, P + HALF + 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_all_zero("rst_hold");
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all_zero("idle_after_abort");
    end
    run_xfer(3'b010, 1'b0, 0);

    for (int r = 0; r < 5; r++) begin
      run_xfer(3'($urandom), 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
